// File: rtl/mmu_pkg.sv
// Shared types for the MMU sequencer and its skew/deskew neighbours.
// Holds the controller state enum and the output-latency derivation.
package mmu_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WLOAD,
    S_WSETTLE,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } mmu_ctrl_state_t;

  // Cycles from an activation read strobe to its result
  // leaving the bottom of the array: buffer read, then
  // DIM rows down plus DIM-1 columns across.
  function automatic int out_lat(input int dim, input int rd_lat);
    return rd_lat + 2 * dim - 1;
  endfunction

endpackage

// File: rtl/mmu_delay_line.sv
// Fixed-depth shift-register delay used to align strobes.
// Ports: clk, rst (sync, active-high), i_d in, o_q = i_d delayed DEPTH cycles.
module mmu_delay_line #(
  parameter int W     = 1,
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_sr [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_sr[i] <= '0;
    end else begin
      r_sr[0] <= i_d;
      for (int i = 1; i < DEPTH; i++) r_sr[i] <= r_sr[i-1];
    end
  end

  assign o_q = r_sr[DEPTH-1];

endmodule

// File: rtl/mmu_ctrl.sv
// Command sequencer for the weight-stationary systolic array:
// weight preload, activation streaming, output-write scheduling.
// Ports: cmd_* handshake/fields in; w_rd_*, a_rd_*, o_wr_* buffer
// strobes/addresses, arr_w_wen/arr_en array entry, busy/done out.
module mmu_ctrl
  import mmu_pkg::*;
#(
  parameter int DIM    = 8,
  parameter int ADDR_W = 10,
  parameter int ROWS_W = 10,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_skip_wload,
  input  logic [ROWS_W-1:0] cmd_num_rows,
  input  logic [ADDR_W-1:0] cmd_w_base,
  input  logic [ADDR_W-1:0] cmd_a_base,
  input  logic [ADDR_W-1:0] cmd_o_base,
  output logic              w_rd_en,
  output logic [ADDR_W-1:0] w_rd_addr,
  output logic              a_rd_en,
  output logic [ADDR_W-1:0] a_rd_addr,
  output logic              arr_w_wen,
  output logic              arr_en,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic              busy,
  output logic              done
);

  localparam int OUT_LAT = out_lat(DIM, RD_LAT);
  localparam int SW      = $clog2(DIM + RD_LAT + 1);
  localparam int CW      = ROWS_W + 1;

  // WSETTLE exits once arr_w_wen has been low for DIM cycles;
  // counting from WSETTLE entry that is DIM+RD_LAT cycles.
  localparam logic [SW-1:0] SETTLE_END = SW'(DIM + RD_LAT - 1);
  localparam logic [SW-1:0] WLOAD_END  = SW'(DIM);

  mmu_ctrl_state_t r_state;

  logic              r_cmd_ready;
  logic              r_busy;
  logic              r_done;
  logic              r_w_rd_en;
  logic [ADDR_W-1:0] r_w_rd_addr;
  logic              r_a_rd_en;
  logic [ADDR_W-1:0] r_a_rd_addr;
  logic [SW-1:0]     r_wcnt;
  logic [CW-1:0]     r_rcnt;
  logic [CW-1:0]     r_m;
  logic [ADDR_W-1:0] r_a_base;

  logic              r_o_wr_en;
  logic [ADDR_W-1:0] r_o_wr_addr;
  logic [ADDR_W-1:0] r_o_ptr;
  logic [CW-1:0]     r_wr_left;

  logic w_accept;
  logic w_wr_pre;
  logic w_arr_w_wen;
  logic w_arr_en;

  assign w_accept = (r_state == S_IDLE) && cmd_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cmd_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_w_rd_en   <= 1'b0;
      r_w_rd_addr <= '0;
      r_a_rd_en   <= 1'b0;
      r_a_rd_addr <= '0;
      r_wcnt      <= '0;
      r_rcnt      <= '0;
      r_m         <= '0;
      r_a_base    <= '0;
    end else begin
      r_done    <= 1'b0;
      r_w_rd_en <= 1'b0;
      r_a_rd_en <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_m         <= {1'b0, cmd_num_rows};
            r_a_base    <= cmd_a_base;
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b1;
            if (!cmd_skip_wload) begin
              // Bottom row first: the chain shifts downward.
              r_state     <= S_WLOAD;
              r_w_rd_en   <= 1'b1;
              r_w_rd_addr <= cmd_w_base + ADDR_W'(DIM - 1);
              r_wcnt      <= SW'(1);
            end else if (cmd_num_rows != '0) begin
              r_state     <= S_STREAM;
              r_a_rd_en   <= 1'b1;
              r_a_rd_addr <= cmd_a_base;
              r_rcnt      <= CW'(1);
            end else begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        S_WLOAD: begin
          if (r_wcnt < WLOAD_END) begin
            r_w_rd_en   <= 1'b1;
            r_w_rd_addr <= r_w_rd_addr - ADDR_W'(1);
            r_wcnt      <= r_wcnt + SW'(1);
          end else begin
            r_state <= S_WSETTLE;
            r_wcnt  <= '0;
          end
        end
        S_WSETTLE: begin
          if (r_wcnt == SETTLE_END) begin
            if (r_m != '0) begin
              r_state     <= S_STREAM;
              r_a_rd_en   <= 1'b1;
              r_a_rd_addr <= r_a_base;
              r_rcnt      <= CW'(1);
            end else begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
          end else begin
            r_wcnt <= r_wcnt + SW'(1);
          end
        end
        S_STREAM: begin
          if (r_rcnt < r_m) begin
            r_a_rd_en   <= 1'b1;
            r_a_rd_addr <= r_a_rd_addr + ADDR_W'(1);
            r_rcnt      <= r_rcnt + CW'(1);
          end else begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          // r_wr_left reaches zero as the last write is registered,
          // so done lands one cycle after that write.
          if (r_wr_left == '0) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          r_state     <= S_IDLE;
          r_busy      <= 1'b0;
          r_cmd_ready <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Output writes follow the activation strobe through a fixed
  // delay, independent of the FSM; one stage is taken by the
  // address register below.
  mmu_delay_line #(
    .W     (1),
    .DEPTH (OUT_LAT - 1)
  ) u_out_dly (
    .clk (clk),
    .rst (rst),
    .i_d (r_a_rd_en),
    .o_q (w_wr_pre)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_o_wr_en   <= 1'b0;
      r_o_wr_addr <= '0;
      r_o_ptr     <= '0;
      r_wr_left   <= '0;
    end else begin
      r_o_wr_en <= w_wr_pre;
      if (w_wr_pre) begin
        r_o_wr_addr <= r_o_ptr;
        r_o_ptr     <= r_o_ptr + ADDR_W'(1);
        r_wr_left   <= r_wr_left - CW'(1);
      end
      if (w_accept) begin
        r_o_ptr   <= cmd_o_base;
        r_wr_left <= {1'b0, cmd_num_rows};
      end
    end
  end

  mmu_delay_line #(
    .W     (1),
    .DEPTH (RD_LAT)
  ) u_wen_dly (
    .clk (clk),
    .rst (rst),
    .i_d (r_w_rd_en),
    .o_q (w_arr_w_wen)
  );

  mmu_delay_line #(
    .W     (1),
    .DEPTH (RD_LAT)
  ) u_en_dly (
    .clk (clk),
    .rst (rst),
    .i_d (r_a_rd_en),
    .o_q (w_arr_en)
  );

  assign cmd_ready = r_cmd_ready;
  assign busy      = r_busy;
  assign done      = r_done;
  assign w_rd_en   = r_w_rd_en;
  assign w_rd_addr = r_w_rd_addr;
  assign a_rd_en   = r_a_rd_en;
  assign a_rd_addr = r_a_rd_addr;
  assign arr_w_wen = w_arr_w_wen;
  assign arr_en    = w_arr_en;
  assign o_wr_en   = r_o_wr_en;
  assign o_wr_addr = r_o_wr_addr;

endmodule

// File: tb/tb_mmu_ctrl.sv
// Directed bench for mmu_ctrl (DIM=4, RD_LAT=1, ADDR_W=10).
// Strobe events are logged with cycle offsets from command acceptance.
module tb_mmu_ctrl;

  localparam int DIM = 4;
  localparam int AW  = 10;
  localparam int RW  = 10;
  localparam int RDL = 1;
  localparam int OL  = 8;
  localparam int AM  = 1024;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_skip_wload = 1'b0;
  logic [RW-1:0] cmd_num_rows = '0;
  logic [AW-1:0] cmd_w_base = '0;
  logic [AW-1:0] cmd_a_base = '0;
  logic [AW-1:0] cmd_o_base = '0;
  logic          w_rd_en;
  logic [AW-1:0] w_rd_addr;
  logic          a_rd_en;
  logic [AW-1:0] a_rd_addr;
  logic          arr_w_wen;
  logic          arr_en;
  logic          o_wr_en;
  logic [AW-1:0] o_wr_addr;
  logic          busy;
  logic          done;

  mmu_ctrl #(
    .DIM    (DIM),
    .ADDR_W (AW),
    .ROWS_W (RW),
    .RD_LAT (RDL)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_skip_wload (cmd_skip_wload),
    .cmd_num_rows   (cmd_num_rows),
    .cmd_w_base     (cmd_w_base),
    .cmd_a_base     (cmd_a_base),
    .cmd_o_base     (cmd_o_base),
    .w_rd_en        (w_rd_en),
    .w_rd_addr      (w_rd_addr),
    .a_rd_en        (a_rd_en),
    .a_rd_addr      (a_rd_addr),
    .arr_w_wen      (arr_w_wen),
    .arr_en         (arr_en),
    .o_wr_en        (o_wr_en),
    .o_wr_addr      (o_wr_addr),
    .busy           (busy),
    .done           (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int acc = 0;
  int ovl = 0;
  int n_chk = 0;
  int n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  int q_wc[$], q_wa[$], q_wen[$], q_ac[$], q_aa[$];
  int q_en[$], q_oc[$], q_oa[$], q_dn[$];
  int e_wc[$], e_wa[$], e_wen[$], e_ac[$], e_aa[$];
  int e_en[$], e_oc[$], e_oa[$], e_dn[$];

  always @(negedge clk) begin
    if (w_rd_en) begin
      q_wc.push_back(cyc - acc + 1);
      q_wa.push_back(int'(w_rd_addr));
    end
    if (arr_w_wen) q_wen.push_back(cyc - acc + 1);
    if (a_rd_en) begin
      q_ac.push_back(cyc - acc + 1);
      q_aa.push_back(int'(a_rd_addr));
    end
    if (arr_en) q_en.push_back(cyc - acc + 1);
    if (o_wr_en) begin
      q_oc.push_back(cyc - acc + 1);
      q_oa.push_back(int'(o_wr_addr));
    end
    if (done) q_dn.push_back(cyc - acc + 1);
    if (w_rd_en && a_rd_en) ovl++;
    if (arr_w_wen && arr_en) ovl++;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cmp_q(input string tag, input int act[$],
                       input int exp[$]);
    chk({tag, "_n"}, act.size(), exp.size());
    for (int i = 0; i < exp.size() && i < act.size(); i++)
      chk(tag, act[i], exp[i]);
  endtask

  task automatic clr();
    q_wc.delete(); q_wa.delete(); q_wen.delete();
    q_ac.delete(); q_aa.delete(); q_en.delete();
    q_oc.delete(); q_oa.delete(); q_dn.delete();
    e_wc.delete(); e_wa.delete(); e_wen.delete();
    e_ac.delete(); e_aa.delete(); e_en.delete();
    e_oc.delete(); e_oa.delete(); e_dn.delete();
    ovl = 0;
  endtask

  // Expected schedule for one command accepted at cycle 'off'.
  task automatic add_exp(input bit skip, input int m, input int wb,
                         input int ab, input int ob, input int off);
    int s;
    s = skip ? 1 : 2 * DIM + RDL + 1;
    if (!skip) begin
      for (int i = 0; i < DIM; i++) begin
        e_wc.push_back(off + 1 + i);
        e_wa.push_back((wb + DIM - 1 - i) % AM);
        e_wen.push_back(off + 1 + RDL + i);
      end
    end
    for (int i = 0; i < m; i++) begin
      e_ac.push_back(off + s + i);
      e_aa.push_back((ab + i) % AM);
      e_en.push_back(off + s + RDL + i);
      e_oc.push_back(off + s + OL + i);
      e_oa.push_back((ob + i) % AM);
    end
    e_dn.push_back(off + ((m == 0) ? s : s + OL + m));
  endtask

  task automatic drive(input bit skip, input int m, input int wb,
                       input int ab, input int ob, input bit set_ref);
    cmd_skip_wload = skip;
    cmd_num_rows   = RW'(m);
    cmd_w_base     = AW'(wb);
    cmd_a_base     = AW'(ab);
    cmd_o_base     = AW'(ob);
    cmd_valid      = 1'b1;
    for (int k = 0; k < 200 && !cmd_ready; k++) @(negedge clk);
    if (!cmd_ready) chk("accept_timeout", 0, 1);
    if (set_ref) acc = cyc + 1;
    @(negedge clk);
  endtask

  task automatic wait_done(input int n);
    for (int k = 0; k < 400 && q_dn.size() < n; k++) @(negedge clk);
    if (q_dn.size() < n) chk("done_timeout", q_dn.size(), n);
    repeat (6) @(negedge clk);
  endtask

  task automatic verify(input string t);
    cmp_q({t, "_wrd_cyc"}, q_wc, e_wc);
    cmp_q({t, "_wrd_adr"}, q_wa, e_wa);
    cmp_q({t, "_wen_cyc"}, q_wen, e_wen);
    cmp_q({t, "_ard_cyc"}, q_ac, e_ac);
    cmp_q({t, "_ard_adr"}, q_aa, e_aa);
    cmp_q({t, "_en_cyc"}, q_en, e_en);
    cmp_q({t, "_owr_cyc"}, q_oc, e_oc);
    cmp_q({t, "_owr_adr"}, q_oa, e_oa);
    cmp_q({t, "_done_cyc"}, q_dn, e_dn);
    chk({t, "_overlap"}, ovl, 0);
    chk({t, "_idle"}, int'({busy, cmd_ready}), 1);
  endtask

  task automatic chk_rst(input string t);
    chk({t, "_ctl"}, int'({w_rd_en, a_rd_en, arr_w_wen, arr_en,
                            o_wr_en, busy, done, cmd_ready}), 1);
    chk({t, "_adr"}, int'({w_rd_addr, a_rd_addr, o_wr_addr}), 0);
  endtask

  task automatic run(input string t, input bit skip, input int m,
                     input int wb, input int ab, input int ob);
    clr();
    add_exp(skip, m, wb, ab, ob, 0);
    drive(skip, m, wb, ab, ob, 1'b1);
    cmd_valid = 1'b0;
    wait_done(1);
    verify(t);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_rst("reset");
    rst = 1'b0;
    @(negedge clk);
    chk_rst("post_reset");

    // Weights 19..16 in cycles 1-4, wen 2-5, writes 32..34 at 18-20.
    run("t1", 1'b0, 3, 16, 0, 32);
    chk("t1_first_wr", q_oc[0], 18);
    chk("t1_done_at", q_dn[0], 21);
    chk("t1_last_wrd", q_wa[3], 16);

    run("t2", 1'b1, 5, 0, 40, 80);
    chk("t2_first_ard", q_ac[0], 1);

    run("t3a", 1'b1, 0, 0, 0, 0);
    chk("t3a_done_at", q_dn[0], 1);
    run("t3b", 1'b0, 0, 100, 0, 0);
    chk("t3b_done_at", q_dn[0], 10);

    // Reset in the middle of a stream.
    clr();
    drive(1'b1, 6, 0, 50, 60, 1'b1);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("t4_streaming", int'(a_rd_en), 1);
    rst = 1'b1;
    @(negedge clk);
    chk_rst("t4_rst");
    rst = 1'b0;
    @(negedge clk);
    run("t4_after", 1'b0, 2, 5, 7, 9);

    run("t5", 1'b1, 4, 0, 1022, 1021);
    chk("t5_wrap_ard", q_aa[2], 0);

    // Valid held across two commands; B is taken when A's
    // cmd_ready returns at cycle 12.
    clr();
    add_exp(1'b1, 2, 0, 100, 200, 0);
    add_exp(1'b1, 3, 0, 300, 400, 12);
    drive(1'b1, 2, 0, 100, 200, 1'b1);
    drive(1'b1, 3, 0, 300, 400, 1'b0);
    cmd_valid = 1'b0;
    wait_done(2);
    verify("t6");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/mmu_ctrl.md
# mmu_ctrl

Sequencer for the DIM x DIM weight-stationary systolic array of `pe` tiles in the MMU. It accepts one matrix-multiply command at a time and runs it in order:

- preload the weight tile through the array's `w_wen` shift chain (skippable);
- stream `num_rows` activation vectors through the row-0 `en` chain;
- drain the pipeline and post results to the output buffer.

Skew registers, buffers and the array itself are outside this block. It drives only read and write addresses, strobes, and the array's entry control.

## Interface
Parameters:
- DIM, 8, array dimension (rows = columns); power of two, minimum 2.
- ADDR_W, 10, buffer address width.
- ROWS_W, 10, width of `num_rows`.
- RD_LAT, 1, weight and activation buffer read latency in cycles (≥1).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  high only in IDLE.
- cmd_skip_wload  in  1  reuse the resident weights; skip preload.
- cmd_num_rows  in  ROWS_W  number of activation vectors M (0 is legal).
- cmd_w_base, cmd_a_base, cmd_o_base  in  ADDR_W each  weight, activation and output base addresses.
- w_rd_en  out  1  weight buffer read strobe.
- w_rd_addr  out  ADDR_W  weight buffer read address.
- a_rd_en  out  1  activation buffer read strobe.
- a_rd_addr  out  ADDR_W  activation buffer read address.
- arr_w_wen  out  1  drives `w_wen_in` of the array's top row.
- arr_en  out  1  drives `en_in` of the row-0 skew input.
- o_wr_en  out  1  output buffer write strobe.
- o_wr_addr  out  ADDR_W  output buffer write address.
- busy  out  1  high whenever the FSM is not in IDLE.
- done  out  1  one-cycle pulse on command completion.

## Operation
- The FSM has six states: IDLE, WLOAD, WSETTLE, STREAM, DRAIN, DONE.
- IDLE: `cmd_ready`=1. On `cmd_valid`, latch all `cmd_*` fields, then go to one of:
  - WLOAD if `skip_wload`=0;
  - STREAM if `skip_wload`=1 and M>0;
  - DONE if `skip_wload`=1 and M=0.
- WLOAD: issue DIM weight reads in reverse row order (`w_base+DIM-1` down to `w_base`), one per cycle. Row DIM-1's weights must enter first because the chain shifts downward.
  - `arr_w_wen` is high for exactly DIM consecutive cycles, starting RD_LAT cycles after the first read, aligned with the returned data.
- WSETTLE: entered after the last read. Wait until `arr_w_wen` has been low for DIM cycles, so the chain's registered `w_wen_out` has fully cleared. Then go to STREAM, or to DONE if M=0.
- STREAM: issue M activation reads at `a_base+i`, i=0..M-1, one per cycle. `arr_en` is high for M consecutive cycles, starting RD_LAT cycles after the first read.
- DRAIN: entered after the last activation read. Remain until the last output write has issued.
- Output writes:
  - OUT_LAT = RD_LAT + 2*DIM - 1.
  - `o_wr_en` is high for M consecutive cycles starting OUT_LAT cycles after the first activation read.
  - `o_wr_addr` = `o_base+i`.
- Write scheduling is driven by a counter/delay line, independent of state. The last write of a command must issue before DONE.
- DONE: `done`=1 for one cycle, then IDLE. `busy` is low in the same cycle `cmd_ready` rises.
- Arithmetic:
  - Addresses wrap modulo 2^ADDR_W, with no error.
  - Row counters are ROWS_W+1 bits wide so M = 2^ROWS_W-1 does not overflow.
- Reset, including mid-command: the next state is IDLE and all in-flight counters clear. Every output is 0 except `cmd_ready`, which is 1. No strobe appears in the cycle after `rst` is sampled high.
- A command offered while busy is not accepted. It must be held until `cmd_ready`.

## Timing
- `cmd_ready`, `busy`, `done` and all strobes and addresses are registered.
- Command sampled at cycle 0:
  - first `w_rd_en` at cycle 1;
  - `arr_w_wen` at cycles 1+RD_LAT .. DIM+RD_LAT.
- STREAM starts at cycle DIM + RD_LAT + DIM + 1.
- `done` fires one cycle after the last `o_wr_en`.
- With `skip_wload`=1, the first `a_rd_en` is at cycle 1.
- Strobes never overlap across phases:
  - `w_rd_en` and `a_rd_en` are never high together.
  - `arr_w_wen` and `arr_en` are never high together.

## Structure
- `mmu_pkg` holds the FSM state enum `mmu_ctrl_state_t` and the `OUT_LAT` derivation function shared with the skew/deskew blocks.
- One sub-module: `mmu_delay_line`, a parameterized shift-register delay for strobe alignment. It is instantiated for the RD_LAT alignment and the OUT_LAT output alignment.

## Test plan
1. DIM=4, RD_LAT=1, M=3, skip=0, `w_base`=16, `a_base`=0, `o_base`=32:
   - weight reads at addresses 19,18,17,16 in cycles 1–4;
   - `arr_w_wen` high in cycles 2–5;
   - `o_wr_en` addresses 32,33,34;
   - `done` one cycle after the last write.
2. skip=1, M=5: no `w_rd_en` or `arr_w_wen` ever; first `a_rd_en` at cycle 1; exactly 5 output writes.
3. M=0:
   - skip=1: `done` at cycle 1 with zero strobes.
   - skip=0: full weight load, then `done`, with no activation or output strobes.
4. `rst` asserted during STREAM: next cycle all strobes are 0, `busy`=0, `cmd_ready`=1. A fresh command then completes with correct addresses.
5. `a_base`=1022, ADDR_W=10, M=4: read addresses 1022,1023,0,1.
6. `cmd_valid` held high across two back-to-back commands: the second is accepted only at `cmd_ready`, with no dropped or duplicated writes, and one `done` per command.
